team_07_button_decoder: RTL and testbench
=========================================

# team_07_button_decoder

Receive-side button front end for the team_07 design. It takes the six raw active-high button pins from the GPIO pads, in the order SELECT, UP, RIGHT, DOWN, LEFT, BACK on bits 0..5. It synchronizes and debounces them and turns each accepted press into a single-cycle strobe with an encoded button code, with optional hold-to-repeat. It sits between the wrapper's GPIO inputs and the game/menu FSM, which consumes only `strobe`/`code`.

## Interface
- `DEBOUNCE_CYCLES`, 4000: cycles a pattern must be stable to count as pressed or released (100 µs at 40 MHz); legal range 1..65535.
- `REPEAT_DELAY`, 0: cycles held after the first strobe before auto-repeat starts; 0 disables repeat.
- `REPEAT_PERIOD`, 2000: cycles between repeat strobes; ignored when `REPEAT_DELAY`=0; must be ≥1.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `en`  in  1  block enable from the wrapper; low acts as a synchronous clear.
- `button_i`  in  6  raw asynchronous button pins, active-high, bit0=SELECT … bit5=BACK.
- `strobe`  out  1  one-cycle pulse per accepted press or repeat.
- `code`  out  3  SELECT=1, UP=2, RIGHT=3, DOWN=4, LEFT=5, BACK=6, 0=none; valid while `strobe`=1 and held until the next strobe or clear.
- `multi`  out  1  accepted pattern had more than one bit set; qualified like `code`.
- `held`  out  1  a debounced press is currently active (state PRESSED).
- `busy`  out  1  state ≠ IDLE.

## Operation
- Two-flop synchronizer on all six bits produces `sync`. The FSM sees only `sync`.
- The FSM has four states: IDLE, DEBOUNCE, PRESSED, RELEASE. `cand` is the 6-bit candidate register. `cnt` is a 16-bit debounce counter. `rcnt` is a 16-bit repeat counter.
- **IDLE:**
  - If `sync`≠0: `cand`←`sync`, `cnt`←0, go to DEBOUNCE.
  - Otherwise stay.
- **DEBOUNCE:**
  - If `sync`==0: go to IDLE with no strobe.
  - If `sync`≠`cand` and nonzero: `cand`←`sync`, `cnt`←0, stay.
  - If `sync`==`cand` and `cnt`==`DEBOUNCE_CYCLES`-1: go to PRESSED; register `strobe`=1, `code`=priority(`cand`), `multi`=popcount(`cand`)>1; `rcnt`←0.
  - Otherwise `cnt`++.
- **Priority:** the lowest set bit wins (SELECT highest).
- **PRESSED:**
  - If `sync`≠`cand`: `cnt`←0, go to RELEASE. This also covers extra buttons added while held; they never strobe.
  - Else, if repeat is enabled: `rcnt`++.
    - First repeat strobe fires when `rcnt` reaches `REPEAT_DELAY`-1.
    - Thereafter `rcnt` reloads so each further strobe is `REPEAT_PERIOD` cycles apart.
    - Repeat strobes carry the same `code`/`multi`.
- **RELEASE:**
  - Requires `sync`==0 for `DEBOUNCE_CYCLES` consecutive cycles; then go to IDLE.
  - Any nonzero `sync` resets `cnt` to 0 and stays in RELEASE. No new press is accepted until a full release.
- **Counters:** all are saturation-free. Parameter ranges guarantee terminal counts fit in 16 bits.

## Timing
- **Reset values** (`nrst`=0 at a clock edge): state IDLE; `strobe`, `code`, `multi`, `held`, `busy`, `cand`, `cnt`, `rcnt` all 0; synchronizer flops 0.
- **`en`=0:** same clear as reset on every edge, taking priority over FSM transitions. Reset or `en` low in mid-DEBOUNCE or mid-PRESSED suppresses any pending strobe.
- **Press latency:** the input changes before edge E0 and is stable thereafter.
  - `sync` is valid after E0+1.
  - FSM enters DEBOUNCE at E0+2.
  - `strobe` is high during the cycle after edge E0+2+`DEBOUNCE_CYCLES`, for exactly one cycle.
- **Repeat latency:** the first repeat strobe follows the initial strobe by `REPEAT_DELAY` cycles; subsequent ones by `REPEAT_PERIOD`.
- **Outputs:** all registered; no combinational path from `button_i`.
- **Simultaneous events:** a `sync` change on the terminal-count edge of DEBOUNCE wins, restarting the count with no strobe.

## Structure
- Package `team_07_button_pkg` holds:
  - the state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - code constants `BTN_SELECT`…`BTN_BACK` and `BTN_NONE`;
  - the bit-index constants shared with the menu FSM.
- One sub-module, `team_07_sync2`: parameterized-width two-flop synchronizer, cleared by `nrst`.
- Priority encoder and popcount are inline functions in the package.

## Test plan
1. `DEBOUNCE_CYCLES`=4000. Press SELECT (6'd1) and hold 20000 cycles, then release. Expect exactly one strobe, 4003 edges after the input change, with `code`=1 and `multi`=0. Expect `busy` low 4003 edges after release.
2. Bounce: toggle UP on for 100 cycles, off for 50, repeated 5 times, then hold. Expect no strobe during bouncing, and one strobe `code`=2 at 4003 edges after the last rising toggle.
3. Press UP|LEFT (6'd18) together. Expect `code`=2, `multi`=1, and one strobe only.
4. Hold RIGHT; after its strobe add DOWN; then release both. Expect no strobe for DOWN. A fresh DOWN press after full release strobes `code`=4.
5. `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4. Hold BACK for 30 cycles. Expect strobes at relative cycles 0, 8, 12, 16, 20 … while held, all with `code`=6.
6. Reset and enable clears:
   - Assert `nrst`=0 at DEBOUNCE `cnt`=2000; release reset with the button still held. Expect all outputs 0, and a strobe a full 4003 edges after reset release.
   - Repeat with `en` low for 1 cycle in PRESSED. Expect `held`→0 and outputs cleared.

Source files
------------

// File: rtl/team_07_button_pkg.sv
// Shared types and constants for the team_07 button front end and the menu FSM.
// Button bit positions, encoded button codes, decoder states and encode helpers.
package team_07_button_pkg;

    localparam int unsigned NUM_BUTTONS = 6;
    localparam int unsigned CODE_W      = 3;
    localparam int unsigned CNT_W       = 16;

    // Bit positions on the raw button bus.
    localparam int unsigned BIT_SELECT = 0;
    localparam int unsigned BIT_UP     = 1;
    localparam int unsigned BIT_RIGHT  = 2;
    localparam int unsigned BIT_DOWN   = 3;
    localparam int unsigned BIT_LEFT   = 4;
    localparam int unsigned BIT_BACK   = 5;

    localparam logic [CODE_W-1:0] BTN_NONE   = 3'd0;
    localparam logic [CODE_W-1:0] BTN_SELECT = 3'd1;
    localparam logic [CODE_W-1:0] BTN_UP     = 3'd2;
    localparam logic [CODE_W-1:0] BTN_RIGHT  = 3'd3;
    localparam logic [CODE_W-1:0] BTN_DOWN   = 3'd4;
    localparam logic [CODE_W-1:0] BTN_LEFT   = 3'd5;
    localparam logic [CODE_W-1:0] BTN_BACK   = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } btn_state_e;

    // Lowest set bit wins, so SELECT outranks everything else.
    function automatic logic [CODE_W-1:0] btn_priority(input logic [NUM_BUTTONS-1:0] pattern);
        logic [CODE_W-1:0] result;
        result = BTN_NONE;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pattern[i]) begin
                result = CODE_W'(i + 1);
            end
        end
        return result;
    endfunction

    function automatic logic [CODE_W-1:0] btn_popcount(input logic [NUM_BUTTONS-1:0] pattern);
        logic [CODE_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            total = total + CODE_W'(pattern[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/team_07_sync2.sv
// Two-flop synchronizer for asynchronous inputs, cleared synchronously by nrst.
module team_07_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;

endmodule

// File: rtl/team_07_button_decoder.sv
// Button front end: synchronize, debounce, and emit one strobe plus code per accepted
// press, with optional hold-to-repeat. Downstream logic only needs strobe/code.
module team_07_button_decoder
    import team_07_button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4000,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 2000
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic [NUM_BUTTONS-1:0] button_i,
    output logic                   strobe,
    output logic [CODE_W-1:0]      code,
    output logic                   multi,
    output logic                   held,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               REPEAT_EN   = (REPEAT_DELAY != 0);

    logic                   sync_clear_n;
    logic [NUM_BUTTONS-1:0] sync;

    btn_state_e             state_q, state_d;
    logic [NUM_BUTTONS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       rcnt_q, rcnt_d;
    logic                   rep_q, rep_d;
    logic                   strobe_q, strobe_d;
    logic [CODE_W-1:0]      code_q, code_d;
    logic                   multi_q, multi_d;
    logic [CNT_W-1:0]       rcnt_last;

    // Disable clears the synchronizer too, so a re-enable starts from a quiet input.
    assign sync_clear_n = nrst & en;

    team_07_sync2 #(
        .WIDTH (NUM_BUTTONS)
    ) u_sync (
        .clk    (clk),
        .nrst   (sync_clear_n),
        .data_i (button_i),
        .data_o (sync)
    );

    // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign rcnt_last = rep_q ? PERIOD_LAST : DELAY_LAST;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        rep_d    = rep_q;
        strobe_d = 1'b0;
        code_d   = code_q;
        multi_d  = multi_q;

        case (state_q)
            StIdle: begin
                if (sync != '0) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = StDebounce;
                end
            end

            StDebounce: begin
                if (sync == '0) begin
                    state_d = StIdle;
                end else if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d  = StPressed;
                    strobe_d = 1'b1;
                    code_d   = btn_priority(cand_q);
                    multi_d  = (btn_popcount(cand_q) > 3'd1);
                    rcnt_d   = '0;
                    rep_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StPressed: begin
                // Any change, including extra buttons, ends the press without a strobe.
                if (sync != cand_q) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == rcnt_last) begin
                        strobe_d = 1'b1;
                        rcnt_d   = '0;
                        rep_d    = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end

            StRelease: begin
                if (sync != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst || !en) begin
            state_q  <= StIdle;
            cand_q   <= '0;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            rep_q    <= 1'b0;
            strobe_q <= 1'b0;
            code_q   <= BTN_NONE;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            rep_q    <= rep_d;
            strobe_q <= strobe_d;
            code_q   <= code_d;
            multi_q  <= multi_d;
        end
    end

    assign strobe = strobe_q;
    assign code   = code_q;
    assign multi  = multi_q;
    assign held   = (state_q == StPressed);
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_team_07_button_decoder.sv
// Directed bench for team_07_button_decoder: a slow-debounce instance for the latency
// scenarios and a fast repeat-enabled instance for the pattern table and repeat timing.
module tb_team_07_button_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic       en_a, en_b;
    logic [5:0] btn_a, btn_b;
    logic       strobe_a, multi_a, held_a, busy_a;
    logic       strobe_b, multi_b, held_b, busy_b;
    logic [2:0] code_a, code_b;

    team_07_button_decoder #(
        .DEBOUNCE_CYCLES (4000),
        .REPEAT_DELAY    (0),
        .REPEAT_PERIOD   (2000)
    ) dut_a (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en_a),
        .button_i (btn_a),
        .strobe   (strobe_a),
        .code     (code_a),
        .multi    (multi_a),
        .held     (held_a),
        .busy     (busy_a)
    );

    team_07_button_decoder #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut_b (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en_b),
        .button_i (btn_b),
        .strobe   (strobe_b),
        .code     (code_b),
        .multi    (multi_b),
        .held     (held_b),
        .busy     (busy_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Strobe logs: cycle index of the edge that raised strobe, plus code/multi.
    int         log_a_t[$];
    logic [2:0] log_a_c[$];
    int         log_b_t[$];
    logic [2:0] log_b_c[$];
    logic       log_b_m[$];
    logic       log_a_m[$];

    always @(negedge clk) begin
        if (strobe_a === 1'b1) begin
            log_a_t.push_back(cyc);
            log_a_c.push_back(code_a);
            log_a_m.push_back(multi_a);
        end
        if (strobe_b === 1'b1) begin
            log_b_t.push_back(cyc);
            log_b_c.push_back(code_b);
            log_b_m.push_back(multi_b);
        end
    end

    typedef struct packed {
        logic [5:0] pattern;
        logic [2:0] code;
        logic       multi;
    } vec_t;

    vec_t vecs[10];
    int   exp_rel[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input bit which_b, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge clk);
            if ((which_b ? busy_b : busy_a) === 1'b0) at = cyc;
        end
    endtask

    task automatic wait_strobe_a(input int n0, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (log_a_t.size() > n0) seen = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, n1, t0, at;
        bit seen;

        vecs[0] = '{6'b000001, 3'd1, 1'b0};
        vecs[1] = '{6'b000010, 3'd2, 1'b0};
        vecs[2] = '{6'b000100, 3'd3, 1'b0};
        vecs[3] = '{6'b001000, 3'd4, 1'b0};
        vecs[4] = '{6'b010000, 3'd5, 1'b0};
        vecs[5] = '{6'b100000, 3'd6, 1'b0};
        vecs[6] = '{6'b010010, 3'd2, 1'b1};
        vecs[7] = '{6'b110000, 3'd5, 1'b1};
        vecs[8] = '{6'b111111, 3'd1, 1'b1};
        vecs[9] = '{6'b101000, 3'd4, 1'b1};
        exp_rel = '{0, 8, 12, 16, 20, 24};

        // Reset state
        nrst = 1'b0; en_a = 1'b1; en_b = 1'b1; btn_a = '0; btn_b = '0;
        repeat (3) @(negedge clk);
        check("rst_strobe", 32'(strobe_a), 0);
        check("rst_code", 32'(code_a), 0);
        check("rst_multi", 32'(multi_a), 0);
        check("rst_held", 32'(held_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Single SELECT press, long hold, release
        n0 = log_a_t.size();
        btn_a = 6'd1; t0 = cyc;
        repeat (5000) @(negedge clk);
        check("t1_count", log_a_t.size() - n0, 1);
        if (log_a_t.size() > n0) begin
            check("t1_latency", log_a_t[n0] - t0, 4003);
            check("t1_code", 32'(log_a_c[n0]), 1);
            check("t1_multi", 32'(log_a_m[n0]), 0);
        end
        check("t1_held", 32'(held_a), 1);
        check("t1_code_hold", 32'(code_a), 1);
        btn_a = 6'd0; t0 = cyc;
        wait_idle(1'b0, 6000, at);
        check("t1_release_latency", at - t0, 4003);
        check("t1_count_after", log_a_t.size() - n0, 1);
        check("t1_code_kept", 32'(code_a), 1);

        // Bouncing UP, then a steady hold
        n0 = log_a_t.size();
        for (int k = 0; k < 5; k++) begin
            btn_a = 6'd2;
            repeat (100) @(negedge clk);
            btn_a = 6'd0;
            repeat (50) @(negedge clk);
        end
        btn_a = 6'd2; t0 = cyc;
        wait_strobe_a(n0, 5000, seen);
        check("t2_strobe_seen", 32'(seen), 1);
        repeat (200) @(negedge clk);
        check("t2_count", log_a_t.size() - n0, 1);
        if (log_a_t.size() > n0) begin
            check("t2_latency", log_a_t[n0] - t0, 4003);
            check("t2_code", 32'(log_a_c[n0]), 2);
        end
        btn_a = 6'd0;
        wait_idle(1'b0, 6000, at);
        check("t2_idle", 32'(at >= 0), 1);

        // RIGHT held, DOWN added, full release, then fresh DOWN
        n0 = log_a_t.size();
        btn_a = 6'd4;
        repeat (4100) @(negedge clk);
        check("t4_right_count", log_a_t.size() - n0, 1);
        check("t4_right_code", 32'(code_a), 3);
        btn_a = 6'd12;
        repeat (100) @(negedge clk);
        check("t4_add_held", 32'(held_a), 0);
        check("t4_add_busy", 32'(busy_a), 1);
        btn_a = 6'd0;
        wait_idle(1'b0, 6000, at);
        check("t4_idle", 32'(at >= 0), 1);
        check("t4_no_down_strobe", log_a_t.size() - n0, 1);
        btn_a = 6'd8;
        repeat (4100) @(negedge clk);
        check("t4_down_count", log_a_t.size() - n0, 2);
        if (log_a_t.size() > n0 + 1) begin
            check("t4_down_code", 32'(log_a_c[n0 + 1]), 4);
            check("t4_down_multi", 32'(log_a_m[n0 + 1]), 0);
        end
        btn_a = 6'd0;
        wait_idle(1'b0, 6000, at);
        check("t4_idle2", 32'(at >= 0), 1);

        // Pattern table on the fast instance; released before any repeat is due
        for (int i = 0; i < 10; i++) begin
            n0 = log_b_t.size();
            @(negedge clk);
            btn_b = vecs[i].pattern; t0 = cyc;
            repeat (8) @(negedge clk);
            check($sformatf("vec%0d_held", i), 32'(held_b), 1);
            btn_b = 6'd0;
            wait_idle(1'b1, 50, at);
            check($sformatf("vec%0d_idle", i), 32'(at >= 0), 1);
            check($sformatf("vec%0d_count", i), log_b_t.size() - n0, 1);
            if (log_b_t.size() > n0) begin
                check($sformatf("vec%0d_latency", i), log_b_t[n0] - t0, 7);
                check($sformatf("vec%0d_code", i), 32'(log_b_c[n0]), 32'(vecs[i].code));
                check($sformatf("vec%0d_multi", i), 32'(log_b_m[n0]), 32'(vecs[i].multi));
            end
        end

        // Hold BACK for 30 cycles with repeat enabled
        n0 = log_b_t.size();
        @(negedge clk);
        btn_b = 6'd32; t0 = cyc;
        repeat (30) @(negedge clk);
        btn_b = 6'd0;
        wait_idle(1'b1, 50, at);
        check("t5_count", log_b_t.size() - n0, 6);
        if (log_b_t.size() > n0) check("t5_first_latency", log_b_t[n0] - t0, 7);
        for (int i = 0; i < 6; i++) begin
            if (log_b_t.size() > n0 + i) begin
                check($sformatf("t5_rel%0d", i), log_b_t[n0 + i] - log_b_t[n0], exp_rel[i]);
                check($sformatf("t5_code%0d", i), 32'(log_b_c[n0 + i]), 6);
            end
        end

        // Reset in mid-debounce with SELECT still held
        n0 = log_a_t.size();
        @(negedge clk);
        btn_a = 6'd1; t0 = cyc;
        repeat (2003) @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_strobe", 32'(strobe_a), 0);
        check("t6_rst_code", 32'(code_a), 0);
        check("t6_rst_multi", 32'(multi_a), 0);
        check("t6_rst_held", 32'(held_a), 0);
        check("t6_rst_busy", 32'(busy_a), 0);
        nrst = 1'b1; t0 = cyc;
        wait_strobe_a(n0, 5000, seen);
        check("t6_strobe_seen", 32'(seen), 1);
        check("t6_count", log_a_t.size() - n0, 1);
        if (log_a_t.size() > n0) check("t6_latency", log_a_t[n0] - t0, 4003);

        // One-cycle disable while PRESSED
        @(negedge clk);
        check("t6_held_before_en", 32'(held_a), 1);
        n1 = log_a_t.size();
        en_a = 1'b0;
        @(negedge clk);
        check("t6_en_held", 32'(held_a), 0);
        check("t6_en_busy", 32'(busy_a), 0);
        check("t6_en_code", 32'(code_a), 0);
        check("t6_en_multi", 32'(multi_a), 0);
        check("t6_en_strobe", 32'(strobe_a), 0);
        en_a = 1'b1; btn_a = 6'd0;
        repeat (50) @(negedge clk);
        check("t6_en_stays_idle", 32'(busy_a), 0);
        check("t6_en_no_strobe", log_a_t.size() - n1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
